alu_arbiter_8085: RTL and testbench

Sequential arbiter that shares the single 8085 pipeline ALU between two requesters: requester 0 is the execute stage, requester 1 is the address/increment unit used for 16-bit pointer updates. It grants the ALU to one requester per cycle and drives the shared ALU operand and op bus. It supports locked multi-beat bursts, so a 16-bit operation runs as two back-to-back 8-bit beats. The ALU result and carry are registered and returned to the granted requester one cycle later.

---
 rtl/alu_arbiter_8085_if.sv | 15 +
 rtl/alu_arbiter_8085.sv | 74 +++++++
 tb/tb_alu_arbiter_8085.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_8085_if.sv
// alu_arbiter_8085_if: requester handshake, shared ALU bus and result return for alu_arbiter_8085
interface alu_arbiter_8085_if #(parameter int WIDTH = 8);
  logic req0, req1, lock0, lock1;
  logic [2:0] op0, op1, alu_op;
  logic [WIDTH-1:0] a0, b0, a1, b1, alu_a, alu_b, alu_y, y;
  logic gnt0, gnt1, alu_cy, cy, vld0, vld1;
  modport slave (
    input  req0, req1, lock0, lock1, op0, op1, a0, b0, a1, b1, alu_y, alu_cy,
    output gnt0, gnt1, alu_op, alu_a, alu_b, y, cy, vld0, vld1
  );
  modport master (
    output req0, req1, lock0, lock1, op0, op1, a0, b0, a1, b1, alu_y, alu_cy,
    input  gnt0, gnt1, alu_op, alu_a, alu_b, y, cy, vld0, vld1
  );
endinterface

// File: rtl/alu_arbiter_8085.sv
// alu_arbiter_8085: shares the 8085 ALU between execute (0) and address unit (1) with locked bursts.
// Define ALU_ARB_RR_EN for round-robin arbitration in IDLE; otherwise requester 0 has fixed priority.
module alu_arbiter_8085 #(
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_arbiter_8085_if.slave  bus
);
  localparam int CW = $clog2(MAX_LOCK);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d, base;
  logic [WIDTH-1:0] y_q, y_d;
  logic cy_q, cy_d, vld0_q, vld0_d, vld1_q, vld1_d;
  logic g0, g1, any, stay, pick0;
`ifdef ALU_ARB_RR_EN
  logic pri_q, pri_d;
  assign pick0 = !pri_q;
`else
  assign pick0 = 1'b1;
`endif
  always_comb begin
    g0 = !rst && ((state_q == LOCK0 && bus.req0) ||
                  (!(state_q == LOCK1 && bus.req1) && bus.req0 && (!bus.req1 || pick0)));
    g1 = !rst && bus.req1 && !g0;
    any = g0 || g1;
    // locked-grant count only carries over while the same owner keeps the ALU
    base = (state_q == (g1 ? LOCK1 : LOCK0)) ? lock_cnt_q : '0;
    stay = any && (g1 ? bus.lock1 : bus.lock0) && base != CW'(MAX_LOCK - 1);
    state_d = stay ? (g1 ? LOCK1 : LOCK0) : IDLE;
    lock_cnt_d = stay ? base + 1'b1 : '0;
    y_d = any ? bus.alu_y : y_q;
    cy_d = any ? bus.alu_cy : cy_q;
    vld0_d = g0;
    vld1_d = g1;
`ifdef ALU_ARB_RR_EN
    pri_d = (any && !stay) ? !g1 : pri_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_cnt_q <= '0;
      y_q <= '0;
      cy_q <= 1'b0;
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      pri_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lock_cnt_q <= lock_cnt_d;
      y_q <= y_d;
      cy_q <= cy_d;
      vld0_q <= vld0_d;
      vld1_q <= vld1_d;
`ifdef ALU_ARB_RR_EN
      pri_q <= pri_d;
`endif
    end
  end
  assign bus.gnt0 = g0;
  assign bus.gnt1 = g1;
  assign bus.alu_op = g1 ? bus.op1 : g0 ? bus.op0 : 3'b000;
  assign bus.alu_a = g1 ? bus.a1 : g0 ? bus.a0 : '0;
  assign bus.alu_b = g1 ? bus.b1 : g0 ? bus.b0 : '0;
  assign bus.y = y_q;
  assign bus.cy = cy_q;
  assign bus.vld0 = vld0_q;
  assign bus.vld1 = vld1_q;
endmodule

// File: tb/tb_alu_arbiter_8085.sv
// tb_alu_arbiter_8085: directed checks of arbitration, locked bursts, forced release and reset.
module tb_alu_arbiter_8085;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;
  logic [8:0] r;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  alu_arbiter_8085_if #(.WIDTH(8)) bus();
  alu_arbiter_8085 #(.WIDTH(8), .MAX_LOCK(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    r = bus.alu_op == 3'd0 ? {1'b0, bus.alu_a} + {1'b0, bus.alu_b} :
        bus.alu_op == 3'd1 ? {1'b0, bus.alu_a} - {1'b0, bus.alu_b} :
        bus.alu_op == 3'd2 ? {1'b0, bus.alu_a & bus.alu_b} :
        bus.alu_op == 3'd3 ? {1'b0, bus.alu_a | bus.alu_b} :
        bus.alu_op == 3'd4 ? {1'b0, bus.alu_a ^ bus.alu_b} : 9'h000;
    bus.alu_y = r[7:0];
    bus.alu_cy = r[8];
  end

  function automatic logic [12:0] obs();
    return {bus.gnt0, bus.gnt1, bus.vld0, bus.vld1, bus.cy, bus.y};
  endfunction

  function automatic logic [20:0] gbus();
    return {bus.gnt0, bus.gnt1, bus.alu_op, bus.alu_a, bus.alu_b};
  endfunction

  task automatic cyc(input logic rs, r0, l0, input logic [2:0] o0, input logic [7:0] x0, z0,
                     input logic r1, l1, input logic [2:0] o1, input logic [7:0] x1, z1);
    @(negedge clk);
    rst = rs;
    bus.req0 = r0; bus.lock0 = l0; bus.op0 = o0; bus.a0 = x0; bus.b0 = z0;
    bus.req1 = r1; bus.lock1 = l1; bus.op1 = o1; bus.a1 = x1; bus.b1 = z1;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 3'd0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    cyc(1, 1, 0, 3'd0, 8'h11, 8'h22, 1, 1, 3'd0, 8'h33, 8'h44);
    cyc(1, 1, 0, 3'd0, 8'h11, 8'h22, 1, 1, 3'd0, 8'h33, 8'h44);
    checks++;
    if (obs() !== 13'h0) $display("FAIL reset_outputs: got %h expected %h", obs(), 13'h0);
    else passed++;
    checks++;
    if (gbus() !== 21'h0) $display("FAIL reset_alu_bus: got %h expected %h", gbus(), 21'h0);
    else passed++;
  endtask

  task automatic test_contention();
    logic [1:0] eg, pg;
    logic [7:0] py;
    pg = 2'b00;
    py = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 3'd0, 8'h01, 8'h02, 1, 0, 3'd4, 8'hF0, 8'h0F);
      eg = (RR && (i % 2) == 1) ? 2'b01 : 2'b10;
      checks++;
      if (obs() !== {eg, pg, 1'b0, py})
        $display("FAIL contention_%0d: got %h expected %h", i, obs(), {eg, pg, 1'b0, py});
      else passed++;
      pg = eg;
      py = eg == 2'b10 ? 8'h03 : 8'hFF;
    end
    idle_cyc();
    checks++;
    if (obs() !== {2'b00, pg, 1'b0, py})
      $display("FAIL contention_last_vld: got %h expected %h", obs(), {2'b00, pg, 1'b0, py});
    else passed++;
    idle_cyc();
    checks++;
    if (obs() !== {2'b00, 2'b00, 1'b0, py})
      $display("FAIL idle_hold: got %h expected %h", obs(), {2'b00, 2'b00, 1'b0, py});
    else passed++;
    checks++;
    if (gbus() !== 21'h0) $display("FAIL idle_alu_bus: got %h expected %h", gbus(), 21'h0);
    else passed++;
  endtask

  task automatic test_single();
    cyc(0, 1, 0, 3'd0, 8'h7F, 8'h01, 0, 0, 3'd0, 8'h00, 8'h00);
    checks++;
    if (gbus() !== {2'b10, 3'd0, 8'h7F, 8'h01})
      $display("FAIL single_gnt: got %h expected %h", gbus(), {2'b10, 3'd0, 8'h7F, 8'h01});
    else passed++;
    idle_cyc();
    checks++;
    if (obs() !== {2'b00, 2'b10, 1'b0, 8'h80})
      $display("FAIL single_result: got %h expected %h", obs(), {2'b00, 2'b10, 1'b0, 8'h80});
    else passed++;
  endtask

  task automatic test_burst();
    cyc(0, 0, 0, 3'd0, 8'h01, 8'h02, 1, 1, 3'd0, 8'hFF, 8'h01);
    checks++;
    if (gbus() !== {2'b01, 3'd0, 8'hFF, 8'h01})
      $display("FAIL burst_beat1: got %h expected %h", gbus(), {2'b01, 3'd0, 8'hFF, 8'h01});
    else passed++;
    cyc(0, 1, 0, 3'd0, 8'h01, 8'h02, 1, 0, 3'd0, 8'h12, 8'h34);
    checks++;
    if (obs() !== {2'b01, 2'b01, 1'b1, 8'h00})
      $display("FAIL burst_beat2: got %h expected %h", obs(), {2'b01, 2'b01, 1'b1, 8'h00});
    else passed++;
    cyc(0, 1, 0, 3'd0, 8'h01, 8'h02, 0, 0, 3'd0, 8'h00, 8'h00);
    checks++;
    if (obs() !== {2'b10, 2'b01, 1'b0, 8'h46})
      $display("FAIL burst_handover: got %h expected %h", obs(), {2'b10, 2'b01, 1'b0, 8'h46});
    else passed++;
    idle_cyc();
    checks++;
    if (obs() !== {2'b00, 2'b10, 1'b0, 8'h03})
      $display("FAIL burst_after: got %h expected %h", obs(), {2'b00, 2'b10, 1'b0, 8'h03});
    else passed++;
  endtask

  task automatic test_forced_release();
    logic [1:0] eg;
    logic [12:0] ev;
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, 1, 3'd2, 8'h3C, 8'h0F, i > 1, 0, 3'd1, 8'h05, 8'h06);
      eg = (RR && i == 5) ? 2'b01 : 2'b10;
      checks++;
      if ({bus.gnt0, bus.gnt1} !== eg)
        $display("FAIL forced_gnt_%0d: got %b expected %b", i, {bus.gnt0, bus.gnt1}, eg);
      else passed++;
    end
    idle_cyc();
    ev = RR ? {2'b00, 2'b01, 1'b1, 8'hFF} : {2'b00, 2'b10, 1'b0, 8'h0C};
    checks++;
    if (obs() !== ev) $display("FAIL forced_after: got %h expected %h", obs(), ev);
    else passed++;
  endtask

  task automatic test_opcode();
    cyc(0, 0, 0, 3'd0, 8'h00, 8'h00, 1, 0, 3'd7, 8'hAA, 8'h55);
    checks++;
    if (gbus() !== {2'b01, 3'd7, 8'hAA, 8'h55})
      $display("FAIL opcode_pass: got %h expected %h", gbus(), {2'b01, 3'd7, 8'hAA, 8'h55});
    else passed++;
    idle_cyc();
    checks++;
    if (obs() !== {2'b00, 2'b01, 1'b0, 8'h00})
      $display("FAIL opcode_result: got %h expected %h", obs(), {2'b00, 2'b01, 1'b0, 8'h00});
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    cyc(0, 0, 0, 3'd0, 8'h01, 8'h01, 1, 1, 3'd0, 8'hFF, 8'h01);
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01)
      $display("FAIL rmb_beat1: got %b expected 01", {bus.gnt0, bus.gnt1});
    else passed++;
    cyc(1, 1, 0, 3'd0, 8'h01, 8'h01, 1, 1, 3'd0, 8'h12, 8'h34);
    checks++;
    if (gbus() !== 21'h0) $display("FAIL rmb_gnt_in_reset: got %h expected %h", gbus(), 21'h0);
    else passed++;
    checks++;
    if (obs() !== {2'b00, 2'b01, 1'b1, 8'h00})
      $display("FAIL rmb_beat1_result: got %h expected %h", obs(), {2'b00, 2'b01, 1'b1, 8'h00});
    else passed++;
    cyc(1, 1, 0, 3'd0, 8'h01, 8'h01, 1, 1, 3'd0, 8'h12, 8'h34);
    checks++;
    if (obs() !== 13'h0) $display("FAIL rmb_vld_in_reset: got %h expected %h", obs(), 13'h0);
    else passed++;
    cyc(0, 1, 0, 3'd0, 8'h01, 8'h01, 1, 1, 3'd0, 8'h12, 8'h34);
    checks++;
    if (obs() !== {2'b10, 2'b00, 1'b0, 8'h00})
      $display("FAIL rmb_rearb: got %h expected %h", obs(), {2'b10, 2'b00, 1'b0, 8'h00});
    else passed++;
    idle_cyc();
    checks++;
    if (obs() !== {2'b00, 2'b10, 1'b0, 8'h02})
      $display("FAIL rmb_after: got %h expected %h", obs(), {2'b00, 2'b10, 1'b0, 8'h02});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_burst();
    test_forced_release();
    test_opcode();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
